tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_if.sv | 28 ++
 rtl/tick_gen.sv | 116 +++++++++++
 tb/tb_tick_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_gen_if.sv
// Control/status bundle between a front-panel source (switch, button,
// rate select) and the tick generator. There is no valid/ready pairing
// here: run and step are free-running asynchronous levels, div_sel is a
// quasi-static select, and tick is a single-cycle enable with no
// back-pressure.
interface tick_gen_if;
    logic       run;
    logic       step;
    logic [4:0] div_sel;
    logic       tick;
    logic [1:0] mode;

    modport master (
        output run,
        output step,
        output div_sel,
        input  tick,
        input  mode
    );

    modport slave (
        input  run,
        input  step,
        input  div_sel,
        output tick,
        output mode
    );
endinterface

// File: rtl/tick_gen.sv
// Tick generator: turns a run switch and a step pushbutton into a
// single-cycle clock enable. In RUN it emits one tick every
// 2^(d_lat+1) cycles. A button press in IDLE emits exactly one tick.
// The mode output exposes the FSM state directly.
module tick_gen #(
    parameter int SYNC_STAGES = 2  // legal range 2..4
) (
    input  logic       clk,
    input  logic       rst,
    tick_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    state_t                 state, state_n;
    logic [31:0]            prescaler, prescaler_n;
    logic [4:0]             d_lat, d_lat_n;
    logic [SYNC_STAGES-1:0] run_sync;
    logic [SYNC_STAGES-1:0] step_sync;
    logic                   step_prev;
    logic                   run_s;
    logic                   step_s;
    logic                   step_edge;
    logic [31:0]            term_val;
    logic                   at_term;

    assign run_s     = run_sync[SYNC_STAGES-1];
    assign step_s    = step_sync[SYNC_STAGES-1];
    assign step_edge = step_s & ~step_prev;

    // Terminal count 2^(d_lat+1)-1 as a right-shifted all-ones mask, so
    // d_lat=31 yields 0xFFFF_FFFF without needing a 33-bit intermediate.
    assign term_val = 32'hFFFF_FFFF >> (5'd31 - d_lat);
    assign at_term  = (prescaler == term_val);

    // Synchronizers. The step chain and its history flop reset to 1 so a
    // button already held when reset releases does not look like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync  <= '0;
            step_sync <= '1;
            step_prev <= 1'b1;
        end else begin
            run_sync  <= {run_sync[SYNC_STAGES-2:0], bus.run};
            step_sync <= {step_sync[SYNC_STAGES-2:0], bus.step};
            step_prev <= step_s;
        end
    end

    // State, prescaler and latched divisor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            d_lat     <= '0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            d_lat     <= d_lat_n;
        end
    end

    // Next-state logic. A step edge seen outside IDLE is consumed by the
    // history flop and never acted on later. The divisor is only sampled
    // on RUN entry and at the period wrap.
    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        d_lat_n     = d_lat;
        unique case (state)
            IDLE: begin
                prescaler_n = '0;
                if (run_s) begin
                    state_n = RUN;
                    d_lat_n = bus.div_sel;
                end else if (step_edge) begin
                    state_n = STEP;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_n     = IDLE;
                    prescaler_n = '0;
                end else if (at_term) begin
                    prescaler_n = '0;
                    d_lat_n     = bus.div_sel;
                end else begin
                    prescaler_n = prescaler + 32'd1;
                end
            end
            STEP: begin
                prescaler_n = '0;
                if (run_s) begin
                    state_n = RUN;
                    d_lat_n = bus.div_sel;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                prescaler_n = '0;
            end
        endcase
    end

    // Outputs come from registered state only. Reset clears state
    // asynchronously, so tick drops the moment rst rises.
    assign bus.tick = (state == STEP) || ((state == RUN) && at_term);
    assign bus.mode = state;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen. Expected tick cycles are queued when the
// stimulus that causes them is driven; a negedge monitor pops and
// compares each tick against the cycle number it is observed in.
module tb_tick_gen;

    localparam int          S      = 2;
    localparam logic [31:0] M_IDLE = 32'd0;
    localparam logic [31:0] M_RUN  = 32'd1;
    localparam logic [31:0] M_STEP = 32'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = 32'd0;
    logic [31:0] n;
    logic [31:0] entry;
    int          hold;
    int          vectors = 0;
    int          errs = 0;
    logic [31:0] exp_q[$];

    tick_gen_if bus ();

    tick_gen #(.SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the posedge that brings cyc to target
    task automatic goto(input logic [31:0] target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0] < cyc) begin
            chk("tick_missed", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (bus.tick === 1'b1) begin
            if (exp_q.size() == 0)
                chk("tick_unexpected", cyc, 32'hFFFF_FFFF);
            else
                chk("tick_cycle", cyc, exp_q.pop_front());
        end
    end

    initial begin
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.div_sel = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode", 32'(bus.mode), M_IDLE);
        chk("rst_tick", 32'(bus.tick), 32'd0);
        chk("rst_prescaler", dut.prescaler, 32'd0);
        chk("rst_dlat", 32'(dut.d_lat), 32'd0);
        rst = 1'b0;

        // free-run, P=8
        n = cyc;
        bus.run = 1'b1;
        entry = n + S + 1;
        for (int k = 0; k < 4; k++) exp_q.push_back(entry + 7 + 8 * k);
        goto(entry - 1);
        chk("run_entry_wait", 32'(bus.mode), M_IDLE);
        goto(entry);
        chk("run_entry", 32'(bus.mode), M_RUN);
        goto(entry + 31);
        bus.run = 1'b0;
        goto(entry + 34);
        chk("run_exit", 32'(bus.mode), M_IDLE);

        // single-step pulses
        for (int p = 0; p < 3; p++) begin
            n = cyc;
            bus.step = 1'b1;
            exp_q.push_back(n + S + 1);
            hold = $urandom_range(2, 6);
            goto(n + 2);
            chk("step_pre", 32'(bus.mode), M_IDLE);
            goto(n + 3);
            chk("step_state", 32'(bus.mode), M_STEP);
            goto(n + 4);
            chk("step_post", 32'(bus.mode), M_IDLE);
            goto(n + 4 + 32'(hold));
            bus.step = 1'b0;
            goto(n + 20);
        end

        // divisor change mid-period: 16 then 2
        bus.div_sel = 5'd3;
        n = cyc;
        bus.run = 1'b1;
        entry = n + S + 1;
        exp_q.push_back(entry + 15);
        exp_q.push_back(entry + 31);
        exp_q.push_back(entry + 33);
        exp_q.push_back(entry + 35);
        exp_q.push_back(entry + 37);
        exp_q.push_back(entry + 39);
        goto(entry + 20);
        bus.div_sel = 5'd0;
        goto(entry + 21);
        chk("dlat_hold", 32'(dut.d_lat), 32'd3);
        goto(entry + 32);
        chk("dlat_reload", 32'(dut.d_lat), 32'd0);
        goto(entry + 37);
        bus.run = 1'b0;
        goto(entry + 40);
        chk("div_exit", 32'(bus.mode), M_IDLE);

        // step pulses during run are dropped; run falls at terminal count
        bus.div_sel = 5'd2;
        n = cyc;
        bus.run = 1'b1;
        entry = n + S + 1;
        exp_q.push_back(entry + 7);
        exp_q.push_back(entry + 15);
        exp_q.push_back(entry + 23);
        goto(entry + 2);
        bus.step = 1'b1;
        goto(entry + 5);
        bus.step = 1'b0;
        goto(entry + 12);
        bus.step = 1'b1;
        goto(entry + 14);
        bus.step = 1'b0;
        goto(entry + 16);
        chk("step_in_run_mode", 32'(bus.mode), M_RUN);
        goto(entry + 21);
        bus.run = 1'b0;
        goto(entry + 23);
        chk("term_mode", 32'(bus.mode), M_RUN);
        chk("term_tick", 32'(bus.tick), 32'd1);
        goto(entry + 24);
        chk("term_exit", 32'(bus.mode), M_IDLE);
        goto(entry + 34);

        // reset between edges while tick is high
        n = cyc;
        bus.run = 1'b1;
        entry = n + S + 1;
        exp_q.push_back(entry + 7);
        goto(entry + 7);
        #5;
        chk("tick_pre_rst", 32'(bus.tick), 32'd1);
        bus.step = 1'b1;
        bus.run  = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_async_tick", 32'(bus.tick), 32'd0);
        chk("rst_async_mode", 32'(bus.mode), M_IDLE);
        chk("rst_async_prescaler", dut.prescaler, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n = cyc;
        goto(n + 10);
        chk("post_rst_idle", 32'(bus.mode), M_IDLE);
        bus.step = 1'b0;
        goto(n + 15);

        // maximum period, prescaler preloaded near the top
        bus.div_sel = 5'd31;
        n = cyc;
        bus.run = 1'b1;
        entry = n + S + 1;
        goto(entry + 4);
        force dut.prescaler = 32'hFFFF_FFFD;
        #1;
        release dut.prescaler;
        exp_q.push_back(entry + 6);
        goto(entry + 6);
        chk("max_term", dut.prescaler, 32'hFFFF_FFFF);
        goto(entry + 7);
        chk("max_wrap", dut.prescaler, 32'd0);
        chk("max_dlat", 32'(dut.d_lat), 32'd31);
        bus.run = 1'b0;
        goto(entry + 10);
        chk("max_exit", 32'(bus.mode), M_IDLE);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
